// File: rtl/benes_tag_data_store.sv
// Per-bank cache tag/data array with optional Benes set-index scramble.
// Optional feature macro: TDS_BENES_PERMUTE_EN.
module benes_tag_data_store #(
    parameter int CACHE_SIZE = 4096,
    parameter int BANK_LINE_SIZE = 16,
    parameter int NUM_BANKS = 4,
    parameter int LINE_ADDR_WIDTH = 26,
    localparam int LINES = CACHE_SIZE / BANK_LINE_SIZE / NUM_BANKS,
    localparam int SET_BITS = $clog2(LINES),
    localparam int TAG_BITS = LINE_ADDR_WIDTH - SET_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall_bank_pipe,
    input  logic [LINE_ADDR_WIDTH-1:0]    read_line_addr,
    output logic                          read_valid,
    output logic                          read_dirty,
    output logic [BANK_LINE_SIZE-1:0]     read_dirtyb,
    output logic [TAG_BITS-1:0]           read_tag,
    output logic [BANK_LINE_SIZE*8-1:0]   read_data,
    input  logic [LINE_ADDR_WIDTH-1:0]    write_line_addr,
    input  logic                          invalidate,
    input  logic                          write_fill,
    input  logic [BANK_LINE_SIZE-1:0]     write_enable,
    input  logic [BANK_LINE_SIZE*8-1:0]   write_data
);

    logic [SET_BITS-1:0] rset;
    logic [SET_BITS-1:0] wset;
    logic [TAG_BITS-1:0] wtag;

    logic [LINES-1:0]            valid_q;
    logic [LINES-1:0]            dirty_q;
    logic [BANK_LINE_SIZE-1:0]   dirtyb_q [LINES];
    logic [TAG_BITS-1:0]         tag_q    [LINES];
    logic [BANK_LINE_SIZE*8-1:0] data_q   [LINES];

    assign wtag = write_line_addr[LINE_ADDR_WIDTH-1:SET_BITS];

`ifdef TDS_BENES_PERMUTE_EN
    function automatic logic [5:0] swp(
        input logic [5:0] x,
        input int         p,
        input int         q,
        input logic       en
    );
        swp = x;
        if (en) begin
            swp[p] = x[q];
            swp[q] = x[p];
        end
    endfunction

    function automatic logic [5:0] benes(input logic [LINE_ADDR_WIDTH-1:0] a);
        logic [7:0]  h;
        logic [11:0] c;
        logic [5:0]  x;
        h = 8'(a >> 18);
        c = a[17:6] ^ {h, 4'b0};
        x = a[5:0];
        x = swp(x, 0, 1, c[0]);
        x = swp(x, 2, 3, c[1]);
        x = swp(x, 4, 5, c[2]);
        x = swp(x, 1, 2, c[3]);
        x = swp(x, 3, 4, c[4]);
        x = swp(x, 5, 0, c[5]);
        x = swp(x, 0, 3, c[6]);
        x = swp(x, 1, 4, c[7]);
        x = swp(x, 2, 5, c[8]);
        x = swp(x, 0, 1, c[9]);
        x = swp(x, 2, 3, c[10]);
        x = swp(x, 4, 5, c[11]);
        return x;
    endfunction

    // Scramble only applies to the 64-set geometry the network is built for
    if (SET_BITS == 6) begin : g_perm
        assign rset = SET_BITS'(benes(read_line_addr));
        assign wset = SET_BITS'(benes(write_line_addr));
    end else begin : g_ident
        assign rset = read_line_addr[SET_BITS-1:0];
        assign wset = write_line_addr[SET_BITS-1:0];
    end
`else
    assign rset = read_line_addr[SET_BITS-1:0];
    assign wset = write_line_addr[SET_BITS-1:0];
`endif

    assign read_valid  = valid_q[rset];
    assign read_dirty  = dirty_q[rset];
    assign read_dirtyb = dirtyb_q[rset];
    assign read_tag    = tag_q[rset];
    assign read_data   = data_q[rset];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                dirtyb_q[i] <= '0;
            end
        end else if (!stall_bank_pipe) begin
            if (invalidate) begin
                valid_q[wset]  <= 1'b0;
                dirty_q[wset]  <= 1'b0;
                dirtyb_q[wset] <= '0;
            end else if (write_fill) begin
                valid_q[wset]  <= 1'b1;
                dirty_q[wset]  <= 1'b0;
                dirtyb_q[wset] <= '0;
            end else if (|write_enable) begin
                dirty_q[wset]  <= 1'b1;
                dirtyb_q[wset] <= dirtyb_q[wset] | write_enable;
            end
        end
    end

    // Tag and data carry no reset; they are meaningless while valid is low
    always_ff @(posedge clk) begin
        if (!stall_bank_pipe && !invalidate) begin
            if (write_fill) begin
                tag_q[wset] <= wtag;
            end
            for (int i = 0; i < BANK_LINE_SIZE; i++) begin
                if (write_enable[i]) begin
                    data_q[wset][i*8 +: 8] <= write_data[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_benes_tag_data_store.sv
// Scoreboard bench for benes_tag_data_store.
// Directed vectors; monitor compares reads on the falling edge.
module tb_benes_tag_data_store;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         stall_bank_pipe = 1'b0;
    logic [25:0]  read_line_addr = '0;
    logic         read_valid;
    logic         read_dirty;
    logic [15:0]  read_dirtyb;
    logic [19:0]  read_tag;
    logic [127:0] read_data;
    logic [25:0]  write_line_addr = '0;
    logic         invalidate = 1'b0;
    logic         write_fill = 1'b0;
    logic [15:0]  write_enable = '0;
    logic [127:0] write_data = '0;

    benes_tag_data_store dut (
        .clk             (clk),
        .reset           (reset),
        .stall_bank_pipe (stall_bank_pipe),
        .read_line_addr  (read_line_addr),
        .read_valid      (read_valid),
        .read_dirty      (read_dirty),
        .read_dirtyb     (read_dirtyb),
        .read_tag        (read_tag),
        .read_data       (read_data),
        .write_line_addr (write_line_addr),
        .invalidate      (invalidate),
        .write_fill      (write_fill),
        .write_enable    (write_enable),
        .write_data      (write_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic         v;
        logic         d;
        logic [15:0]  db;
        bit           ct;
        logic [19:0]  tg;
        bit           cd;
        logic [127:0] dt;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;
    int   rd_id = 0;
    logic sample = 1'b0;

    localparam logic [127:0] A5 = {4{32'hA5A5A5A5}};

    task automatic cmp(input string f, input int id,
                       input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL rd%0d.%s actual=%h required=%h", id, f, act, req);
    endtask

    always @(negedge clk) begin
        if (sample) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL scoreboard_underflow actual=0 required=1");
            end else begin
                exp_t e;
                e = q.pop_front();
                cmp("valid", e.id, 128'(read_valid), 128'(e.v));
                cmp("dirty", e.id, 128'(read_dirty), 128'(e.d));
                cmp("dirtyb", e.id, 128'(read_dirtyb), 128'(e.db));
                if (e.ct) cmp("tag", e.id, 128'(read_tag), 128'(e.tg));
                if (e.cd) cmp("data", e.id, read_data, e.dt);
            end
        end
    end

    task automatic push(input logic v, input logic d, input logic [15:0] db,
                        input bit ct, input logic [19:0] tg,
                        input bit cd, input logic [127:0] dt);
        exp_t e;
        e.id = rd_id;
        e.v = v;
        e.d = d;
        e.db = db;
        e.ct = ct;
        e.tg = tg;
        e.cd = cd;
        e.dt = dt;
        rd_id++;
        q.push_back(e);
    endtask

    task automatic rd(input logic [25:0] a, input logic v, input logic d,
                      input logic [15:0] db, input bit ct, input logic [19:0] tg,
                      input bit cd, input logic [127:0] dt);
        @(posedge clk);
        #1;
        read_line_addr = a;
        push(v, d, db, ct, tg, cd, dt);
        sample = 1'b1;
        @(negedge clk);
        #1;
        sample = 1'b0;
    endtask

    task automatic rd0(input logic [25:0] a);
        rd(a, 1'b0, 1'b0, 16'h0, 1'b0, 20'h0, 1'b0, 128'h0);
    endtask

    task automatic wr(input logic [25:0] a, input logic inv, input logic fl,
                      input logic st, input logic [15:0] we, input logic [127:0] d);
        @(posedge clk);
        #1;
        write_line_addr = a;
        invalidate = inv;
        write_fill = fl;
        stall_bank_pipe = st;
        write_enable = we;
        write_data = d;
        @(posedge clk);
        #1;
        invalidate = 1'b0;
        write_fill = 1'b0;
        stall_bank_pipe = 1'b0;
        write_enable = '0;
        write_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 64; i++) rd0(26'(i));

        wr(26'h5, 1'b0, 1'b1, 1'b0, 16'hFFFF, A5);
        rd(26'h5, 1'b1, 1'b0, 16'h0, 1'b1, 20'h0, 1'b1, A5);

        wr(26'h5, 1'b0, 1'b0, 1'b0, 16'h000F,
           {96'h0123456789ABCDEF01234567, 32'hDEADBEEF});
        rd(26'h5, 1'b1, 1'b1, 16'h000F, 1'b1, 20'h0, 1'b1,
           {A5[127:32], 32'hDEADBEEF});

        wr(26'h5, 1'b0, 1'b0, 1'b1, 16'hFFFF, 128'h0);
        wr(26'h5, 1'b1, 1'b0, 1'b1, 16'h0, 128'h0);
        rd(26'h5, 1'b1, 1'b1, 16'h000F, 1'b1, 20'h0, 1'b1,
           {A5[127:32], 32'hDEADBEEF});

        wr(26'h5, 1'b1, 1'b0, 1'b0, 16'hFFFF, 128'h0);
        rd0(26'h5);

        wr(26'h5, 1'b0, 1'b0, 1'b0, 16'h0F00, {4{32'h11111111}});
        rd(26'h5, 1'b0, 1'b1, 16'h0F00, 1'b0, 20'h0, 1'b0, 128'h0);

        wr(26'h5, 1'b0, 1'b1, 1'b0, 16'h00F0, {4{32'h22222222}});
        rd(26'h5, 1'b1, 1'b0, 16'h0, 1'b1, 20'h0, 1'b1,
           {32'hA5A5A5A5, 32'h11111111, 32'h22222222, 32'hDEADBEEF});

        wr(26'h7, 1'b0, 1'b1, 1'b0, 16'hFFFF, {4{32'h77777777}});
        rd(26'h7, 1'b1, 1'b0, 16'h0, 1'b1, 20'h0, 1'b1, {4{32'h77777777}});
        wr(26'h7, 1'b1, 1'b1, 1'b0, 16'hFFFF, 128'h0);
        rd0(26'h7);

        wr(26'h41, 1'b0, 1'b1, 1'b0, 16'hFFFF, {4{32'h41414141}});
`ifdef TDS_BENES_PERMUTE_EN
        rd(26'h02, 1'b1, 1'b0, 16'h0, 1'b1, 20'h1, 1'b1, {4{32'h41414141}});
        rd0(26'h01);
`else
        rd(26'h41, 1'b1, 1'b0, 16'h0, 1'b1, 20'h1, 1'b1, {4{32'h41414141}});
        rd0(26'h02);
`endif

        @(posedge clk);
        #1;
        write_line_addr = 26'h9;
        write_fill = 1'b1;
        write_enable = 16'hFFFF;
        write_data = {4{32'h99999999}};
        read_line_addr = 26'h5;
        push(1'b0, 1'b0, 16'h0, 1'b0, 20'h0, 1'b0, 128'h0);
        sample = 1'b1;
        #2;
        reset = 1'b1;
        @(negedge clk);
        #1;
        sample = 1'b0;
        @(posedge clk);
        #1;
        write_fill = 1'b0;
        write_enable = '0;
        write_data = '0;
        reset = 1'b0;

        rd0(26'h9);
        rd0(26'h5);
        rd0(26'h41);
        rd0(26'h7);

        @(posedge clk);
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain actual=%0d required=0", q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
